// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
//   Shared types and March C- element tables for the SRAM March BIST engine.
//   Element tables are packed vectors where bit N describes element EN:
//     ELEM_DOWN   : element walks addresses DEPTH-1 .. 0
//     ELEM_HAS_RD : element reads each address
//     ELEM_HAS_WR : element writes each address
//     ELEM_RD_INV : read expects ~B(a) instead of B(a)
//     ELEM_WR_INV : write stores ~B(a) instead of B(a)
// -----------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } bist_state_t;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } march_elem_t;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_ADDR    = 2'd2,
    PAT_RSVD    = 2'd3
  } pattern_t;

  localparam int NUM_ELEMS = 6;

  //                                        E5 E4 E3 E2 E1 E0
  localparam logic [NUM_ELEMS-1:0] ELEM_DOWN   = 6'b1_1_1_0_0_0;
  localparam logic [NUM_ELEMS-1:0] ELEM_HAS_RD = 6'b1_1_1_1_1_0;
  localparam logic [NUM_ELEMS-1:0] ELEM_HAS_WR = 6'b0_1_1_1_1_1;
  localparam logic [NUM_ELEMS-1:0] ELEM_RD_INV = 6'b0_1_0_1_0_0;
  localparam logic [NUM_ELEMS-1:0] ELEM_WR_INV = 6'b0_0_1_0_1_0;

endpackage

// File: rtl/bist_compare_pipe.sv
// -----------------------------------------------------------------------------
// bist_compare_pipe
//   Delays the compare tag of each read so it lines up with the SRAM read data
//   RD_LAT cycles later.
// Ports
//   Clock, Resetn        clock, async active-low reset (clears valid bits only)
//   tag_vld/exp/addr/elem tag registered alongside the SRAM address
//   cmp_vld/exp/addr/elem tag aligned with BIST_read_data
// -----------------------------------------------------------------------------
module bist_compare_pipe
  import bist_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              tag_vld,
  input  logic [DATA_W-1:0] tag_exp,
  input  logic [ADDR_W-1:0] tag_addr,
  input  march_elem_t       tag_elem,
  output logic              cmp_vld,
  output logic [DATA_W-1:0] cmp_exp,
  output logic [ADDR_W-1:0] cmp_addr,
  output march_elem_t       cmp_elem
);

  logic              vld_p  [RD_LAT];
  logic [DATA_W-1:0] exp_p  [RD_LAT];
  logic [ADDR_W-1:0] addr_p [RD_LAT];
  march_elem_t       elem_p [RD_LAT];

  // ---- stages p0 .. p(RD_LAT-1): valid bits are flushed by reset ----
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= tag_vld;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge Clock) begin
    exp_p[0]  <= tag_exp;
    addr_p[0] <= tag_addr;
    elem_p[0] <= tag_elem;
    for (int i = 1; i < RD_LAT; i++) begin
      exp_p[i]  <= exp_p[i-1];
      addr_p[i] <= addr_p[i-1];
      elem_p[i] <= elem_p[i-1];
    end
  end

  assign cmp_vld  = vld_p[RD_LAT-1];
  assign cmp_exp  = exp_p[RD_LAT-1];
  assign cmp_addr = addr_p[RD_LAT-1];
  assign cmp_elem = elem_p[RD_LAT-1];

endmodule

// File: rtl/sram_march_bist.sv
// -----------------------------------------------------------------------------
// sram_march_bist
//   March C- BIST engine for a single-port SRAM with fixed read latency.
//   Runs E0 up w0; E1 up r0,w1; E2 up r1,w0; E3 down r0,w1; E4 down r1,w0;
//   E5 down r0 over addresses 0..DEPTH-1 with a selectable background, and
//   records a sticky mismatch, a saturating fail count and the first failure.
// Ports
//   Clock, Resetn       clock (rising edge), async active-low reset
//   BIST_start          rising edge in IDLE starts a run
//   BIST_pattern        background select, latched at start
//   BIST_address        registered SRAM address
//   BIST_write_data     registered SRAM write data
//   BIST_we_n           registered SRAM write enable, active low
//   BIST_read_data      SRAM read data, valid RD_LAT cycles after its address
//   BIST_finish         high while idle / after completion
//   BIST_mismatch       sticky compare failure for the current run
//   BIST_fail_count     saturating mismatch count
//   BIST_fail_address   address of the first mismatch
//   BIST_fail_element   March element of the first mismatch
// -----------------------------------------------------------------------------
module sram_march_bist
  import bist_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              BIST_start,
  input  logic [1:0]        BIST_pattern,
  output logic [ADDR_W-1:0] BIST_address,
  output logic [DATA_W-1:0] BIST_write_data,
  output logic              BIST_we_n,
  input  logic [DATA_W-1:0] BIST_read_data,
  output logic              BIST_finish,
  output logic              BIST_mismatch,
  output logic [15:0]       BIST_fail_count,
  output logic [ADDR_W-1:0] BIST_fail_address,
  output logic [2:0]        BIST_fail_element
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Background word B(a); the reserved code falls back to solid zeros.
  function automatic logic [DATA_W-1:0] background(pattern_t pat, logic [ADDR_W-1:0] a);
    logic [DATA_W+ADDR_W-1:0] ext;
    logic [DATA_W-1:0]        chk;
    ext = {{DATA_W{1'b0}}, a};
    for (int i = 0; i < DATA_W; i++) chk[i] = ((i % 2) == 0) ? ~a[0] : a[0];
    case (pat)
      PAT_CHECKER: background = chk;
      PAT_ADDR:    background = ext[DATA_W-1:0];
      default:     background = '0;
    endcase
  endfunction

  bist_state_t       state_q, state_d;
  march_elem_t       elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;   // 0: read slot, 1: write slot of an r,w element
  logic [2:0]        drain_q, drain_d;
  pattern_t          pat_q;
  logic              start_buf;
  logic              start_go;
  logic              drain_done;

  logic              is_rw, do_read, last_op_here, at_end;
  logic [DATA_W-1:0] bg;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_data_d;
  logic              bus_we_n_d;
  logic              rd_vld_d;
  logic [DATA_W-1:0] exp_d;

  logic              rd_vld_p0;
  logic [DATA_W-1:0] exp_p0;
  march_elem_t       elem_p0;

  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  march_elem_t       cmp_elem;
  logic              cmp_fail;
  march_elem_t       fail_elem_q;

  // The counters describe the op being issued this cycle; the bus registers
  // present it to the SRAM one cycle later, so DRAIN runs RD_LAT+1 state
  // cycles to cover the RD_LAT bus cycles after the last read is on the bus.
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    phase_d    = phase_q;
    drain_d    = drain_q;
    bus_addr_d = BIST_address;
    bus_data_d = BIST_write_data;
    bus_we_n_d = 1'b1;
    rd_vld_d   = 1'b0;
    exp_d      = exp_p0;

    start_go     = BIST_start & ~start_buf & (state_q == ST_IDLE);
    drain_done   = (state_q == ST_DRAIN) && (drain_q == 3'(RD_LAT));
    bg           = background(pat_q, addr_q);
    is_rw        = ELEM_HAS_RD[elem_q] & ELEM_HAS_WR[elem_q];
    do_read      = ELEM_HAS_RD[elem_q] & ~(is_rw & phase_q);
    last_op_here = ~is_rw | phase_q;
    at_end       = ELEM_DOWN[elem_q] ? (addr_q == '0) : (addr_q == LAST_ADDR);

    case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d = ST_RUN;
          elem_d  = E0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      ST_RUN: begin
        bus_addr_d = addr_q;
        if (do_read) begin
          rd_vld_d = 1'b1;
          exp_d    = ELEM_RD_INV[elem_q] ? ~bg : bg;
        end else begin
          bus_we_n_d = 1'b0;
          bus_data_d = ELEM_WR_INV[elem_q] ? ~bg : bg;
        end
        if (last_op_here) begin
          phase_d = 1'b0;
          if (at_end) begin
            if (elem_q == E5) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end else begin
              elem_d = march_elem_t'(elem_q + 3'd1);
              addr_d = ELEM_DOWN[elem_d] ? LAST_ADDR : '0;
            end
          end else begin
            addr_d = ELEM_DOWN[elem_q] ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
          end
        end else begin
          phase_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_IDLE;
        else            drain_d = drain_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- stage p0: SRAM bus and read tag registered together ----
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q         <= ST_IDLE;
      elem_q          <= E0;
      addr_q          <= '0;
      phase_q         <= 1'b0;
      drain_q         <= '0;
      pat_q           <= PAT_SOLID;
      start_buf       <= 1'b0;
      BIST_address    <= '0;
      BIST_write_data <= '0;
      BIST_we_n       <= 1'b1;
      rd_vld_p0       <= 1'b0;
      BIST_finish     <= 1'b1;
    end else begin
      state_q         <= state_d;
      elem_q          <= elem_d;
      addr_q          <= addr_d;
      phase_q         <= phase_d;
      drain_q         <= drain_d;
      start_buf       <= BIST_start;
      BIST_address    <= bus_addr_d;
      BIST_write_data <= bus_data_d;
      BIST_we_n       <= bus_we_n_d;
      rd_vld_p0       <= rd_vld_d;
      if (start_go) pat_q <= pattern_t'(BIST_pattern);
      if (start_go)        BIST_finish <= 1'b0;
      else if (drain_done) BIST_finish <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    exp_p0  <= exp_d;
    elem_p0 <= elem_q;
  end

  // ---- stages p1..: tag delayed to meet the read data ----
  bist_compare_pipe #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_cmp_pipe (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .tag_vld  (rd_vld_p0),
    .tag_exp  (exp_p0),
    .tag_addr (BIST_address),
    .tag_elem (elem_p0),
    .cmp_vld  (cmp_vld),
    .cmp_exp  (cmp_exp),
    .cmp_addr (cmp_addr),
    .cmp_elem (cmp_elem)
  );

  assign cmp_fail = cmp_vld & (BIST_read_data != cmp_exp);

  // ---- compare stage: sticky flag, saturating count, first-fail capture ----
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      BIST_mismatch     <= 1'b0;
      BIST_fail_count   <= '0;
      BIST_fail_address <= '0;
      fail_elem_q       <= E0;
    end else if (start_go) begin
      BIST_mismatch     <= 1'b0;
      BIST_fail_count   <= '0;
      BIST_fail_address <= '0;
      fail_elem_q       <= E0;
    end else if (cmp_fail) begin
      BIST_mismatch <= 1'b1;
      if (BIST_fail_count != 16'hFFFF) BIST_fail_count <= BIST_fail_count + 16'd1;
      if (BIST_fail_count == 16'd0) begin
        BIST_fail_address <= cmp_addr;
        fail_elem_q       <= cmp_elem;
      end
    end
  end

  assign BIST_fail_element = fail_elem_q;

endmodule

// File: tb/tb_sram_march_bist.sv
module tb_sram_march_bist;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;
  localparam int NOPS   = 10 * DEPTH;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              BIST_start = 1'b0;
  logic [1:0]        BIST_pattern = 2'd0;
  logic [ADDR_W-1:0] BIST_address;
  logic [DATA_W-1:0] BIST_write_data;
  logic              BIST_we_n;
  logic [DATA_W-1:0] BIST_read_data;
  logic              BIST_finish;
  logic              BIST_mismatch;
  logic [15:0]       BIST_fail_count;
  logic [ADDR_W-1:0] BIST_fail_address;
  logic [2:0]        BIST_fail_element;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  sram_march_bist #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clock             (Clock),
    .Resetn            (Resetn),
    .BIST_start        (BIST_start),
    .BIST_pattern      (BIST_pattern),
    .BIST_address      (BIST_address),
    .BIST_write_data   (BIST_write_data),
    .BIST_we_n         (BIST_we_n),
    .BIST_read_data    (BIST_read_data),
    .BIST_finish       (BIST_finish),
    .BIST_mismatch     (BIST_mismatch),
    .BIST_fail_count   (BIST_fail_count),
    .BIST_fail_address (BIST_fail_address),
    .BIST_fail_element (BIST_fail_element)
  );

  always #5 Clock = ~Clock;

  // Fault configuration: 0 none, 1 stuck-at bit, 2 coupling (write aggr inverts vict)
  int   f_kind = 0;
  int   f_addr = 0;
  int   f_bit  = 0;
  logic f_val  = 1'b0;
  int   c_aggr = 0;
  int   c_vict = 0;

  // ---------------- SRAM model with fixed read latency ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  function automatic logic [DATA_W-1:0] apply_stuck(int a, logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    if (f_kind == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] model_read(logic [ADDR_W-1:0] a);
    if (int'(a) < DEPTH) return apply_stuck(int'(a), mem[a]);
    return 'x;
  endfunction

  always @(posedge Clock) begin
    if (BIST_we_n == 1'b0 && int'(BIST_address) < DEPTH) begin
      mem[BIST_address] <= apply_stuck(int'(BIST_address), BIST_write_data);
      if (f_kind == 2 && int'(BIST_address) == c_aggr) mem[c_vict] <= ~mem[c_vict];
    end
    rd_pipe[0] <= model_read(BIST_address);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign BIST_read_data = rd_pipe[RD_LAT-1];

  // ---------------- reference: March C- op list and outcome ----------------
  typedef struct {
    logic              we_n;
    int                addr;
    logic [DATA_W-1:0] data;   // write data, or expected read data
    int                elem;
  } op_t;

  op_t ops[$];
  // per element: read polarity / write polarity, -1 when the op is absent
  int RD_OF [6] = '{-1, 0, 1, 0, 1, 0};
  int WR_OF [6] = '{ 0, 1, 0, 1, 0, -1};

  function automatic logic [DATA_W-1:0] bgw(int pat, int a);
    case (pat)
      1:       return (a % 2 == 0) ? 16'h5555 : 16'hAAAA;
      2:       return DATA_W'(a);
      default: return '0;
    endcase
  endfunction

  task automatic build_ops(input int pat);
    op_t o;
    int  a;
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < DEPTH; s++) begin
        a = (e >= 3) ? (DEPTH - 1 - s) : s;
        o.addr = a;
        o.elem = e;
        if (RD_OF[e] >= 0) begin
          o.we_n = 1'b1;
          o.data = (RD_OF[e] == 1) ? ~bgw(pat, a) : bgw(pat, a);
          ops.push_back(o);
        end
        if (WR_OF[e] >= 0) begin
          o.we_n = 1'b0;
          o.data = (WR_OF[e] == 1) ? ~bgw(pat, a) : bgw(pat, a);
          ops.push_back(o);
        end
      end
    end
  endtask

  task automatic predict(output int nf, output int fa, output int fe);
    logic [DATA_W-1:0] m [DEPTH];
    logic [DATA_W-1:0] got;
    nf = 0; fa = 0; fe = 0;
    foreach (ops[i]) begin
      if (ops[i].we_n == 1'b0) begin
        m[ops[i].addr] = apply_stuck(ops[i].addr, ops[i].data);
        if (f_kind == 2 && ops[i].addr == c_aggr) m[c_vict] = ~m[c_vict];
      end else begin
        got = apply_stuck(ops[i].addr, m[ops[i].addr]);
        if (got !== ops[i].data) begin
          if (nf == 0) begin fa = ops[i].addr; fe = ops[i].elem; end
          if (nf < 65535) nf++;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_finish"},     BIST_finish, 1);
    chk({tag, "_we_n"},       BIST_we_n, 1);
    chk({tag, "_address"},    BIST_address, 0);
    chk({tag, "_wdata"},      BIST_write_data, 0);
    chk({tag, "_mismatch"},   BIST_mismatch, 0);
    chk({tag, "_count"},      BIST_fail_count, 0);
    chk({tag, "_fail_addr"},  BIST_fail_address, 0);
    chk({tag, "_fail_elem"},  BIST_fail_element, 0);
  endtask

  // start_mode 0: one-cycle start pulse; 1: start held high and toggled mid-run.
  // reset_at >= 0: Resetn pulled low at that cycle index instead of completing.
  task automatic run_bist(input int pat, input int start_mode, input int reset_at, input string tag);
    int nf, fa, fe, idx, bad;
    logic bad_here;
    build_ops(pat);
    predict(nf, fa, fe);
    @(negedge Clock);
    BIST_pattern = 2'(pat);
    BIST_start   = 1'b1;
    @(negedge Clock);
    if (start_mode == 0) BIST_start = 1'b0;
    BIST_pattern = 2'($urandom_range(0, 3));
    idx = 0;
    bad = 0;
    while (BIST_finish === 1'b0 && idx < 400) begin
      if (idx >= 1 && idx <= NOPS)
        bad_here = (BIST_we_n !== ops[idx-1].we_n) || (int'(BIST_address) != ops[idx-1].addr) ||
                   (ops[idx-1].we_n == 1'b0 && BIST_write_data !== ops[idx-1].data);
      else
        bad_here = (BIST_we_n !== 1'b1);
      if (bad_here) begin
        if (bad == 0 && idx >= 1 && idx <= NOPS)
          $display("%s trace: first bad cycle %0d got we_n=%0b addr=%0d data=%0h want we_n=%0b addr=%0d data=%0h",
                   tag, idx, BIST_we_n, BIST_address, BIST_write_data,
                   ops[idx-1].we_n, ops[idx-1].addr, ops[idx-1].data);
        bad++;
      end
      if (start_mode == 1) begin
        if (idx == 20 || idx == 50) BIST_start = 1'b0;
        if (idx == 21 || idx == 51) BIST_start = 1'b1;
      end
      if (idx == reset_at) begin
        chk({tag, "_trace_before_reset"}, bad, 0);
        Resetn = 1'b0;
        @(negedge Clock);
        check_reset_values({tag, "_midreset"});
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
        check_reset_values({tag, "_after_release"});
        return;
      end
      idx++;
      @(negedge Clock);
    end
    chk({tag, "_finish_low_cycles"}, idx, NOPS + 1 + RD_LAT);
    chk({tag, "_bus_trace_errors"}, bad, 0);
    chk({tag, "_mismatch"}, BIST_mismatch, (nf != 0));
    chk({tag, "_fail_count"}, BIST_fail_count, nf);
    chk({tag, "_fail_addr"}, BIST_fail_address, fa);
    chk({tag, "_fail_elem"}, BIST_fail_element, fe);
    if (start_mode == 1) begin
      repeat (6) @(negedge Clock);
      chk({tag, "_no_second_run"}, BIST_finish, 1);
      BIST_start = 1'b0;
      repeat (3) @(negedge Clock);
      chk({tag, "_count_after_hold"}, BIST_fail_count, nf);
    end
    @(negedge Clock);
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    Resetn = 1'b0;
    repeat (3) @(negedge Clock);
    check_reset_values("reset");
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    chk("idle_finish", BIST_finish, 1);

    // clean memory, solid background
    f_kind = 0;
    run_bist(0, 0, -1, "clean_p0");
    chk("clean_p0_mismatch_zero", BIST_mismatch, 0);

    // bit 3 stuck-at-1 at address 5
    f_kind = 1; f_addr = 5; f_bit = 3; f_val = 1'b1;
    run_bist(0, 0, -1, "stuck");
    chk("stuck_addr_is_5", BIST_fail_address, 5);
    chk("stuck_elem_is_1", BIST_fail_element, 1);
    chk("stuck_count_is_3", BIST_fail_count, 3);

    // write to 2 inverts 6, checkerboard
    f_kind = 2; c_aggr = 2; c_vict = 6;
    run_bist(1, 0, -1, "coupling");
    chk("coupling_detected", BIST_mismatch, 1);
    chk("coupling_elem_le4", (BIST_fail_element <= 3'd4), 1);

    // remaining backgrounds on a clean memory
    f_kind = 0;
    run_bist(2, 0, -1, "clean_p2");
    run_bist(3, 0, -1, "clean_p3");

    // reset in the middle of E3 (cycle 41..56 carry E3 ops)
    f_kind = 1; f_addr = 5; f_bit = 3; f_val = 1'b1;
    run_bist(0, 0, 45, "reset_e3");
    f_kind = 0;
    run_bist(int'($urandom_range(0, 2)), 0, -1, "post_reset");
    chk("post_reset_clean", BIST_fail_count, 0);

    // start held high and toggled during the run
    f_kind = 1; f_addr = 2; f_bit = 0; f_val = 1'b1;
    run_bist(0, 1, -1, "hold_start");

    // randomized faults and backgrounds
    for (int r = 0; r < 5; r++) begin
      f_kind = int'($urandom_range(0, 2));
      f_addr = int'($urandom_range(0, DEPTH - 1));
      f_bit  = int'($urandom_range(0, DATA_W - 1));
      f_val  = 1'($urandom_range(0, 1));
      c_aggr = int'($urandom_range(0, DEPTH - 1));
      c_vict = (c_aggr + int'($urandom_range(1, DEPTH - 1))) % DEPTH;
      run_bist(int'($urandom_range(0, 3)), 0, -1, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
